// File: rtl/barrett_modred_if.sv
// barrett_modred_if: configuration, input and result signals of the Barrett reducer.
//   cfg_we/cfg_q/cfg_mu : configuration load strobe, modulus q and constant mu (master -> slave)
//   cfg_err             : rejected-load pulse (slave -> master)
//   in_valid/in_data    : 2K-bit product to reduce (master -> slave)
//   out_valid/out_data  : reduced K-bit result (slave -> master)
//   busy                : at least one valid in flight (slave -> master)
interface barrett_modred_if #(
   parameter int unsigned LOG_Q = 32
);
   logic                   cfg_we;
   logic [LOG_Q-1:0]       cfg_q;
   logic [LOG_Q:0]         cfg_mu;
   logic                   cfg_err;
   logic                   in_valid;
   logic [2*LOG_Q-1:0]     in_data;
   logic                   out_valid;
   logic [LOG_Q-1:0]       out_data;
   logic                   busy;

   modport master (
      output cfg_we, cfg_q, cfg_mu, in_valid, in_data,
      input  cfg_err, out_valid, out_data, busy
   );

   modport slave (
      input  cfg_we, cfg_q, cfg_mu, in_valid, in_data,
      output cfg_err, out_valid, out_data, busy
   );
endinterface

// File: rtl/barrett_modred.sv
// barrett_modred: pipelined Barrett reduction of a 2K-bit product modulo a run-time q.
// Fixed latency LAT = 2*INTMUL_LAT+5, one result per cycle, no backpressure.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : barrett_modred_if slave (config, input product, reduced output, busy)
module barrett_modred #(
   parameter int unsigned LOG_Q       = 32,
   parameter string       INTMUL_TYPE = "fpga_dsp",
   parameter int unsigned INTMUL_LAT  = 4
) (
   input logic              clk,
   input logic              rst_n,
   barrett_modred_if.slave  bus
);
   localparam int unsigned K   = LOG_Q;
   localparam int unsigned LAT = 2 * INTMUL_LAT + 5;
   localparam int unsigned RW  = K + 2;
   localparam int unsigned M1W = 2 * K + 2;
   // DSP-style multipliers register their operands as the first of their latency stages.
   localparam int unsigned OP_REGS  = (INTMUL_TYPE == "fpga_dsp") ? 1 : 0;
   localparam int unsigned PRD_REGS = INTMUL_LAT - OP_REGS;
   // c must wait for M1, the t2 register and M2 before it meets t3.
   localparam int unsigned C_DLY = 2 * INTMUL_LAT + 1;

   // ---------------- control: valid pipeline and configuration ----------------
   logic [LAT-1:0] vld_d, vld_q;
   logic [K-1:0]   q_d, q_q;
   logic [K:0]     mu_d, mu_q;
   logic           cfg_err_d, cfg_err_q;
   logic [K-1:0]   out_data_d, out_data_q;
   logic           busy;

   assign busy = |vld_q;

   always_comb begin
      vld_d     = {vld_q[LAT-2:0], bus.in_valid};
      q_d       = q_q;
      mu_d      = mu_q;
      cfg_err_d = 1'b0;
      if (bus.cfg_we) begin
         // Loading while anything is in flight (or arriving) would corrupt those results.
         if (busy || bus.in_valid) begin
            cfg_err_d = 1'b1;
         end else begin
            q_d  = bus.cfg_q;
            mu_d = bus.cfg_mu;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q      <= '0;
         q_q        <= '0;
         mu_q       <= '0;
         cfg_err_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         vld_q      <= vld_d;
         q_q        <= q_d;
         mu_q       <= mu_d;
         cfg_err_q  <= cfg_err_d;
         out_data_q <= out_data_d;
      end
   end

   // ---------------- data pipeline (no reset) ----------------
   logic [2*K-1:0] c_d, c_q;
   logic [K:0]     m1_a, m1_b;
   logic [K:0]     t1s_d [PRD_REGS];
   logic [K:0]     t1s_q [PRD_REGS];
   logic [K:0]     t2_d, t2_q;
   logic [RW-1:0]  m2_a, m2_b;
   logic [RW-1:0]  t3_d [PRD_REGS];
   logic [RW-1:0]  t3_q [PRD_REGS];
   logic [RW-1:0]  cd_d [C_DLY];
   logic [RW-1:0]  cd_q [C_DLY];
   logic [RW-1:0]  r_d, r_q, q_ext;
   logic [K:0]     r1_d, r1_q;

   assign q_ext = {2'b00, q_q};

   if (OP_REGS == 1) begin : g_op_regs
      logic [K:0]    a1_d, a1_q, b1_d, b1_q;
      logic [RW-1:0] a2_d, a2_q, b2_d, b2_q;
      always_comb begin
         a1_d = c_q[2*K-1:K-1];
         b1_d = mu_q;
         a2_d = {1'b0, t2_q};
         b2_d = q_ext;
      end
      always_ff @(posedge clk) begin
         a1_q <= a1_d;
         b1_q <= b1_d;
         a2_q <= a2_d;
         b2_q <= b2_d;
      end
      assign m1_a = a1_q;
      assign m1_b = b1_q;
      assign m2_a = a2_q;
      assign m2_b = b2_q;
   end else begin : g_op_comb
      assign m1_a = c_q[2*K-1:K-1];
      assign m1_b = mu_q;
      assign m2_a = {1'b0, t2_q};
      assign m2_b = q_ext;
   end

   always_comb begin
      c_d = bus.in_data;
      // M1 keeps only t1 >> (K+1); the low bits never matter.
      t1s_d[0] = (K+1)'(({{(K+1){1'b0}}, m1_a} * {{(K+1){1'b0}}, m1_b}) >> (K+1));
      for (int i = 1; i < PRD_REGS; i++) t1s_d[i] = t1s_q[i-1];
      t2_d = t1s_q[PRD_REGS-1];
      // M2 only needs t3 mod 2^(K+2), since r is taken modulo the same width.
      t3_d[0] = m2_a * m2_b;
      for (int i = 1; i < PRD_REGS; i++) t3_d[i] = t3_q[i-1];
      cd_d[0] = c_q[RW-1:0];
      for (int i = 1; i < C_DLY; i++) cd_d[i] = cd_q[i-1];
      r_d  = cd_q[C_DLY-1] - t3_q[PRD_REGS-1];
      // r < 3q, so two conditional subtractions finish the reduction.
      r1_d = (K+1)'((r_q >= q_ext) ? r_q - q_ext : r_q);
   end

   always_ff @(posedge clk) begin
      c_q   <= c_d;
      t1s_q <= t1s_d;
      t2_q  <= t2_d;
      t3_q  <= t3_d;
      cd_q  <= cd_d;
      r_q   <= r_d;
      r1_q  <= r1_d;
   end

   // Output register holds its last value when no result is due.
   always_comb begin
      out_data_d = out_data_q;
      if (vld_q[LAT-2]) begin
         out_data_d = K'((r1_q >= {1'b0, q_q}) ? r1_q - {1'b0, q_q} : r1_q);
      end
   end

   assign bus.out_valid = vld_q[LAT-1];
   assign bus.out_data  = out_data_q;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_barrett_modred.sv
module tb_barrett_modred;
   localparam int unsigned K   = 14;
   localparam int          LAT = 13;
   localparam int          Q1  = 12289;
   localparam int          MU1 = 21843;
   localparam int          Q2  = 8193;
   localparam int          MU2 = 32764;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   barrett_modred_if #(.LOG_Q(K)) bus ();

   barrett_modred #(
      .LOG_Q      (K),
      .INTMUL_TYPE("fpga_dsp"),
      .INTMUL_LAT (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_data[$];
   int exp_cyc[$];

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
   endtask

   // Scoreboard monitor: every out_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      int e, ec;
      if (rst_n && bus.out_valid) begin
         if (exp_data.size() == 0) begin
            check("unexpected out_valid", int'(bus.out_valid), 0);
         end else begin
            e  = exp_data.pop_front();
            ec = exp_cyc.pop_front();
            check("out_data", int'(bus.out_data), e);
            check("latency", cyc, ec);
         end
      end
   end

   task automatic send(input int x, input int e);
      bus.in_valid = 1'b1;
      bus.in_data  = x[2*K-1:0];
      exp_data.push_back(e);
      exp_cyc.push_back(cyc + LAT);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_cfg(input int q, input int mu);
      bus.cfg_we = 1'b1;
      bus.cfg_q  = q[K-1:0];
      bus.cfg_mu = mu[K:0];
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy drains", int'(bus.busy), 0);
   endtask

   initial begin
      int x;
      int ks[6];
      int offs[7];
      int sx[6];
      int se[6];
      ks   = '{0, 1, 2, 100, 6000, 12287};
      offs = '{0, 1, 2, 3, 12286, 12287, 12288};
      sx   = '{0, 8193, 8194, 16385, 24579, 67108864};
      se   = '{0, 0, 1, 8192, 0, 1};

      bus.cfg_we   = 1'b0;
      bus.cfg_q    = '0;
      bus.cfg_mu   = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", int'(bus.out_valid), 0);
      check("reset out_data", int'(bus.out_data), 0);
      check("reset busy", int'(bus.busy), 0);
      check("reset cfg_err", int'(bus.cfg_err), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_cfg(Q1, MU1);
      check("idle cfg accepted", int'(bus.cfg_err), 0);

      // Basic values, back to back.
      send(0, 0);
      send(12289, 0);
      send(12290, 1);
      send(150994944, 1);
      wait_idle();

      // Near multiples of q, exercising both correction subtractions.
      foreach (ks[i]) foreach (offs[j]) send(ks[i] * Q1 + offs[j], offs[j]);
      wait_idle();

      // Streaming random products below q^2.
      repeat (200) begin
         x = int'($urandom_range(32'd151019520, 32'd0));
         send(x, x % Q1);
      end
      wait_idle();

      // Reset with five results in flight.
      for (int i = 0; i < 5; i++) send(1000 + i * 7777, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_data.delete();
      exp_cyc.delete();
      #1;
      check("reset mid-stream out_valid", int'(bus.out_valid), 0);
      check("reset mid-stream busy", int'(bus.busy), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("busy after reset release", int'(bus.busy), 0);
      check("q cleared by reset", int'(dut.q_q), 0);

      // Config guard: load while busy is rejected and the old q stays.
      do_cfg(Q1, MU1);
      send(20000, 7711);
      @(posedge clk); #1;
      do_cfg(Q2, MU2);
      check("cfg_err while busy", int'(bus.cfg_err), 1);
      @(posedge clk); #1;
      check("cfg_err single pulse", int'(bus.cfg_err), 0);
      send(13000, 711);
      wait_idle();

      // Load in the same cycle as an input: rejected, input uses old q.
      bus.cfg_we   = 1'b1;
      bus.cfg_q    = Q2[K-1:0];
      bus.cfg_mu   = MU2[K:0];
      send(12290, 1);
      bus.cfg_we   = 1'b0;
      check("cfg_err with in_valid", int'(bus.cfg_err), 1);
      wait_idle();

      // Idle load accepted.
      do_cfg(Q2, MU2);
      check("idle cfg q2 accepted", int'(bus.cfg_err), 0);
      send(8194, 1);
      send(16386, 0);
      send(8192, 8192);
      wait_idle();

      // Sparse inputs on alternate cycles; latency check confirms the pattern.
      foreach (sx[i]) begin
         send(sx[i], se[i]);
         @(posedge clk); #1;
      end
      wait_idle();

      check("scoreboard drained", exp_data.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
